soc_bus_fabric: RTL

//  Parametrised CPU-to-peripheral interconnect for FemtoRV32 SoCs. Replaces hard-wired per-device decode/readback muxing.

---
 rtl/soc_bus_fabric_if.sv | 43 ++++
 rtl/soc_bus_fabric.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/soc_bus_fabric_if.sv
// CPU-side and peripheral-side signals of the SoC bus fabric, bundled.
// Modport slave is the fabric's view (it serves the CPU and drives the peripherals).
// Modport master is the environment's view (the CPU and peripherals driving the fabric).
interface soc_bus_fabric_if #(
  parameter int NUM_SLAVES = 4
);
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_wmask;
  logic                     mem_rstrb;
  logic [31:0]              mem_rdata;
  logic                     mem_rbusy;
  logic                     mem_wbusy;
  logic [31:0]              s_addr;
  logic [31:0]              s_wdata;
  logic [3:0]               s_wstrb;
  logic [NUM_SLAVES-1:0]    s_ren;
  logic [NUM_SLAVES-1:0]    s_wen;
  logic [32*NUM_SLAVES-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]    s_rvalid;
  logic [NUM_SLAVES-1:0]    s_wready;
  logic                     err_clr;
  logic                     bus_err;
  logic [31:0]              err_addr;

  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata, mem_rbusy, mem_wbusy,
    output s_addr, s_wdata, s_wstrb, s_ren, s_wen,
    input  s_rdata, s_rvalid, s_wready,
    input  err_clr,
    output bus_err, err_addr
  );

  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata, mem_rbusy, mem_wbusy,
    input  s_addr, s_wdata, s_wstrb, s_ren, s_wen,
    output s_rdata, s_rvalid, s_wready,
    output err_clr,
    input  bus_err, err_addr
  );
endinterface

// File: rtl/soc_bus_fabric.sv
// CPU-to-peripheral interconnect: base/mask address decode, registered local-bus request, error termination.
// Latency: request registered on the strobe edge; 0-wait read returns data 2 cycles after rstrb.
// Backpressure: CPU is held off through mem_rbusy/mem_wbusy until rvalid/wready, a timeout or a decode miss.
module soc_bus_fabric #(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{32'hF000_0000}},
  parameter int                       TIMEOUT    = 255,
  parameter int                       TO_W       = 8,
  parameter logic [31:0]              ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  soc_bus_fabric_if.slave   bus
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // The wait ends in error once the counter would reach TIMEOUT, so at most TIMEOUT wait cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ERR} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic [31:0]      hit_mask;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      req_addr;
  logic             req_wr;
  logic [TO_W-1:0]  cnt;
  logic             rsp_rvalid;
  logic             rsp_wready;
  logic [31:0]      rsp_rdata;
  logic             wr_req;
  logic             accept;

  assign wr_req     = |bus.mem_wmask;
  assign accept     = (state == IDLE) && (wr_req || bus.mem_rstrb);
  assign rsp_rvalid = bus.s_rvalid[req_idx];
  assign rsp_wready = bus.s_wready[req_idx];
  assign rsp_rdata  = bus.s_rdata[32*req_idx +: 32];

  // Address decode; scanning downwards lets the lowest-index window win on overlap.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    hit_mask = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit_any  = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_mask = SLAVE_MASK[32*i +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and busy flags; a response beats a timeout in the same cycle.
  always_comb begin
    state_nxt     = state;
    bus.mem_rbusy = 1'b0;
    bus.mem_wbusy = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req)             state_nxt = hit_any ? WR_WAIT : ERR;
        else if (bus.mem_rstrb) state_nxt = hit_any ? RD_WAIT : ERR;
      end
      RD_WAIT: begin
        bus.mem_rbusy = 1'b1;
        if (rsp_rvalid)          state_nxt = IDLE;
        else if (cnt == TO_LAST) state_nxt = ERR;
      end
      WR_WAIT: begin
        bus.mem_wbusy = 1'b1;
        if (rsp_wready)          state_nxt = IDLE;
        else if (cnt == TO_LAST) state_nxt = ERR;
      end
      ERR: begin
        bus.mem_rbusy = !req_wr;
        bus.mem_wbusy = req_wr;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, single-cycle slave strobes and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_idx     <= '0;
      req_addr    <= '0;
      req_wr      <= 1'b0;
      cnt         <= '0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.s_wstrb <= '0;
      bus.s_ren   <= '0;
      bus.s_wen   <= '0;
    end else begin
      bus.s_ren <= '0;
      bus.s_wen <= '0;
      if (accept) begin
        req_idx     <= hit_idx;
        req_addr    <= bus.mem_addr;
        req_wr      <= wr_req;
        cnt         <= '0;
        bus.s_addr  <= bus.mem_addr & ~hit_mask;
        bus.s_wdata <= bus.mem_wdata;
        bus.s_wstrb <= bus.mem_wmask;
        if (hit_any) begin
          if (wr_req) bus.s_wen <= NUM_SLAVES'(1) << hit_idx;
          else        bus.s_ren <= NUM_SLAVES'(1) << hit_idx;
        end
      end else if (state == RD_WAIT || state == WR_WAIT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Read data register: holds until the next read completes, normally or in error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_rdata <= '0;
    end else if (state == RD_WAIT && rsp_rvalid) begin
      bus.mem_rdata <= rsp_rdata;
    end else if (state == ERR && !req_wr) begin
      bus.mem_rdata <= ERR_DATA;
    end
  end

  // Sticky error flag; clear wins over a same-cycle set, err_addr keeps the first failing address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_err  <= 1'b0;
      bus.err_addr <= '0;
    end else if (bus.err_clr) begin
      bus.bus_err <= 1'b0;
    end else if (state == ERR) begin
      bus.bus_err <= 1'b1;
      if (!bus.bus_err) bus.err_addr <= req_addr;
    end
  end

endmodule
